// File: rtl/neopixel_pkg.sv
// Shared NeoPixel timing defaults, decoder FSM states and GRB field positions.
package neopixel_pkg;

  localparam int unsigned ThreshCyclesDef  = 30;
  localparam int unsigned MaxHighCyclesDef = 60;
  localparam int unsigned ResetCyclesDef   = 2500;

  localparam int unsigned PixelW = 24;
  localparam int unsigned GMsb   = 23;
  localparam int unsigned GLsb   = 16;
  localparam int unsigned RMsb   = 15;
  localparam int unsigned RLsb   = 8;
  localparam int unsigned BMsb   = 7;
  localparam int unsigned BLsb   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StWaitGap
  } np_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/neopixel_decoder.sv
// Decodes a NeoPixel (WS2812-style) serial stream into 24-bit GRB words with frame tracking.
module neopixel_decoder
  import neopixel_pkg::*;
#(
  parameter int unsigned THRESH_CYCLES   = ThreshCyclesDef,
  parameter int unsigned MAX_HIGH_CYCLES = MaxHighCyclesDef,
  parameter int unsigned RESET_CYCLES    = ResetCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DI,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [15:0] pixel_count,
  output logic        error
);

  localparam int unsigned HighW = $clog2(MAX_HIGH_CYCLES) + 1;
  localparam int unsigned LowW  = $clog2(RESET_CYCLES) + 1;

  localparam logic [HighW-1:0] Thresh   = HighW'(THRESH_CYCLES);
  localparam logic [HighW-1:0] MaxHigh  = HighW'(MAX_HIGH_CYCLES);
  localparam logic [LowW-1:0]  GapLim   = LowW'(RESET_CYCLES);
  localparam logic [LowW-1:0]  GapLast  = LowW'(RESET_CYCLES - 1);

  logic w_di;
  logic w_rise;
  logic w_bit;

  np_state_e        r_state,       w_state_nxt;
  logic             r_di_prev;
  logic [HighW-1:0] r_high_cnt,    w_high_cnt_nxt;
  logic [LowW-1:0]  r_low_cnt,     w_low_cnt_nxt;
  logic [4:0]       r_bit_cnt,     w_bit_cnt_nxt;
  logic [23:0]      r_word,        w_word_nxt;
  logic [23:0]      r_pixel_data,  w_pixel_data_nxt;
  logic             r_pixel_valid, w_pixel_valid_nxt;
  logic             r_frame_done,  w_frame_done_nxt;
  logic [15:0]      r_pixel_count, w_pixel_count_nxt;
  logic             r_error,       w_error_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (DI),
    .o_q   (w_di)
  );

  assign w_rise = w_di & ~r_di_prev;
  assign w_bit  = (r_high_cnt >= Thresh);

  always_comb begin
    w_state_nxt       = r_state;
    w_high_cnt_nxt    = r_high_cnt;
    w_low_cnt_nxt     = r_low_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_word_nxt        = r_word;
    w_pixel_data_nxt  = r_pixel_data;
    w_pixel_valid_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_error_nxt       = 1'b0;
    // Count holds through the frame_done cycle, then clears.
    w_pixel_count_nxt = r_frame_done ? 16'd0 : r_pixel_count;

    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_nxt    = StHigh;
          w_high_cnt_nxt = HighW'(1);
        end
      end
      StHigh: begin
        if (!w_di) begin
          w_state_nxt   = StLow;
          w_low_cnt_nxt = LowW'(1);
          w_word_nxt    = {r_word[22:0], w_bit};
          if (r_bit_cnt == 5'd23) begin
            w_bit_cnt_nxt     = 5'd0;
            w_pixel_data_nxt  = {r_word[22:0], w_bit};
            w_pixel_valid_nxt = 1'b1;
            if (r_pixel_count != 16'hFFFF) begin
              w_pixel_count_nxt = r_pixel_count + 16'd1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end else if (r_high_cnt >= MaxHigh) begin
          // This cycle would make the pulse MAX_HIGH_CYCLES+1 long.
          w_state_nxt   = StWaitGap;
          w_error_nxt   = 1'b1;
          w_bit_cnt_nxt = 5'd0;
          w_word_nxt    = 24'h000000;
          w_low_cnt_nxt = '0;
        end else begin
          w_high_cnt_nxt = r_high_cnt + HighW'(1);
        end
      end
      StLow: begin
        if (w_di) begin
          w_state_nxt    = StHigh;
          w_high_cnt_nxt = HighW'(1);
          w_low_cnt_nxt  = '0;
        end else if (r_low_cnt >= GapLast) begin
          w_state_nxt      = StIdle;
          w_low_cnt_nxt    = GapLim;
          w_frame_done_nxt = 1'b1;
          w_error_nxt      = (r_bit_cnt != 5'd0);
          w_bit_cnt_nxt    = 5'd0;
          w_word_nxt       = 24'h000000;
        end else begin
          w_low_cnt_nxt = r_low_cnt + LowW'(1);
        end
      end
      StWaitGap: begin
        if (w_di) begin
          w_low_cnt_nxt = '0;
        end else if (r_low_cnt >= GapLast) begin
          w_state_nxt      = StIdle;
          w_low_cnt_nxt    = GapLim;
          w_frame_done_nxt = 1'b1;
        end else begin
          w_low_cnt_nxt = r_low_cnt + LowW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_di_prev     <= 1'b0;
      r_high_cnt    <= '0;
      r_low_cnt     <= '0;
      r_bit_cnt     <= 5'd0;
      r_word        <= 24'h000000;
      r_pixel_data  <= 24'h000000;
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_pixel_count <= 16'd0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_di_prev     <= w_di;
      r_high_cnt    <= w_high_cnt_nxt;
      r_low_cnt     <= w_low_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_word        <= w_word_nxt;
      r_pixel_data  <= w_pixel_data_nxt;
      r_pixel_valid <= w_pixel_valid_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_pixel_count <= w_pixel_count_nxt;
      r_error       <= w_error_nxt;
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign frame_done  = r_frame_done;
  assign pixel_count = r_pixel_count;
  assign error       = r_error;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Directed-vector bench for neopixel_decoder: words, gaps, pulse-width boundaries and reset.
module tb_neopixel_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        DI;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic [15:0] pixel_count;
  logic        error;

  neopixel_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .DI          (DI),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .error       (error)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [23:0] q_pix[$];
  int          n_fd;
  int          n_err;
  logic [15:0] fd_cnt;
  logic [15:0] cnt_after;
  logic        fd_err;
  logic        fd_prev;

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (pixel_valid) q_pix.push_back(pixel_data);
    if (error) n_err = n_err + 1;
    if (fd_prev) cnt_after = pixel_count;
    if (frame_done) begin
      n_fd   = n_fd + 1;
      fd_cnt = pixel_count;
      fd_err = error;
    end
    fd_prev = frame_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    return (q_pix.size() > i) ? q_pix[i] : 24'hBADBAD;
  endfunction

  task automatic clr_mon();
    @(posedge clk);
    q_pix.delete();
    n_fd      = 0;
    n_err     = 0;
    fd_cnt    = 16'hDEAD;
    cnt_after = 16'hBEEF;
    fd_err    = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    DI = 1'b1;
    repeat (hi) @(negedge clk);
    DI = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w[23-i]) pulse(40, 20);
      else         pulse(20, 40);
    end
  endtask

  task automatic gap();
    DI = 1'b0;
    repeat (2600) @(negedge clk);
  endtask

  initial begin
    fd_prev = 1'b0;
    DI      = 1'b0;
    reset   = 1'b1;
    clr_mon();
    repeat (5) @(negedge clk);
    check("rst_data",  32'(pixel_data),  32'h0);
    check("rst_valid", 32'(pixel_valid), 32'h0);
    check("rst_fd",    32'(frame_done),  32'h0);
    check("rst_count", 32'(pixel_count), 32'h0);
    check("rst_err",   32'(error),       32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single word followed by a latch gap
    clr_mon();
    send_bits(24'h00FF00, 24);
    gap();
    check("w1_nvalid", 32'(q_pix.size()), 32'd1);
    check("w1_data",   32'(pix(0)),       32'h00FF00);
    check("w1_nfd",    32'(n_fd),         32'd1);
    check("w1_fdcnt",  32'(fd_cnt),       32'd1);
    check("w1_cntclr", 32'(cnt_after),    32'd0);
    check("w1_nerr",   32'(n_err),        32'd0);

    // Three back-to-back words
    clr_mon();
    send_bits(24'h1BCDEF, 24);
    send_bits(24'hBDC345, 24);
    send_bits(24'h9BD942, 24);
    gap();
    check("w3_nvalid", 32'(q_pix.size()), 32'd3);
    check("w3_d0",     32'(pix(0)),       32'h1BCDEF);
    check("w3_d1",     32'(pix(1)),       32'hBDC345);
    check("w3_d2",     32'(pix(2)),       32'h9BD942);
    check("w3_fdcnt",  32'(fd_cnt),       32'd3);
    check("w3_cntclr", 32'(cnt_after),    32'd0);

    // Partial word: 10 bits then gap
    clr_mon();
    send_bits(24'hFFFFFF, 10);
    gap();
    check("pw_nvalid", 32'(q_pix.size()), 32'd0);
    check("pw_nerr",   32'(n_err),        32'd1);
    check("pw_fderr",  32'(fd_err),       32'd1);
    check("pw_nfd",    32'(n_fd),         32'd1);
    check("pw_fdcnt",  32'(fd_cnt),       32'd0);
    check("pw_keep",   32'(pixel_data),   32'h9BD942);

    // Threshold and max-width boundaries: 29->0, 30->1, 60->1
    clr_mon();
    pulse(29, 40);
    pulse(30, 40);
    pulse(60, 40);
    send_bits(24'h0ABCDE << 3, 21);
    gap();
    check("th_nvalid", 32'(q_pix.size()), 32'd1);
    check("th_data",   32'(pix(0)),       32'h6ABCDE);
    check("th_nerr",   32'(n_err),        32'd0);

    // 61-cycle pulse is an error; following bits ignored until the gap
    clr_mon();
    send_bits(24'h800000, 2);
    pulse(61, 40);
    send_bits(24'hFFFFFF, 24);
    gap();
    check("ov_nerr",   32'(n_err),        32'd1);
    check("ov_nvalid", 32'(q_pix.size()), 32'd0);
    check("ov_nfd",    32'(n_fd),         32'd1);
    check("ov_fderr",  32'(fd_err),       32'd0);
    clr_mon();
    send_bits(24'h3C5A96, 24);
    gap();
    check("ov_next_n", 32'(q_pix.size()), 32'd1);
    check("ov_next_d", 32'(pix(0)),       32'h3C5A96);

    // Reset mid-word discards silently
    clr_mon();
    send_bits(24'hABCDEF, 12);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("mr_data0",  32'(pixel_data),  32'h0);
    check("mr_count0", 32'(pixel_count), 32'h0);
    repeat (10) @(negedge clk);
    send_bits(24'h123456, 24);
    gap();
    check("mr_nerr",   32'(n_err),        32'd0);
    check("mr_nvalid", 32'(q_pix.size()), 32'd1);
    check("mr_data",   32'(pixel_data),   32'h123456);
    check("mr_fdcnt",  32'(fd_cnt),       32'd1);

    // Low of RESET_CYCLES-1 between bits is not a gap
    clr_mon();
    send_bits(24'hC3A55A, 7);
    pulse(40, 2499);
    send_bits(24'hC3A55A << 8, 16);
    gap();
    check("lg_nfd",    32'(n_fd),         32'd1);
    check("lg_nvalid", 32'(q_pix.size()), 32'd1);
    check("lg_data",   32'(pix(0)),       32'hC3A55A);
    check("lg_nerr",   32'(n_err),        32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
